game_status_tx: RTL

//  Transmit side of the inter-board game link. Turns local game events into
//  3-byte frames: local ready/start, Donkey hit with remaining health, match

---
 rtl/game_status_tx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/game_status_tx.sv
// game_status_tx
//   Transmit side of the inter-board game link. Local game events are latched
//   into pending flags. Each flag is sent as a 3-byte frame: HDR, PAY, CHK.
//   HDR = {4'hA, type}. CHK = HDR ^ PAY.
//   Frame types are READY=1, HIT=2, RESULT=3 and HBEAT=4.
//   Bytes go to a UART transmitter over a valid/ready handshake.
//
// Parameters
//   HEARTBEAT_CYCLES  clk cycles between heartbeat frames while game_en=1 (>=4)
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   start_game  in   1  local player ready level
//   game_en     in   1  game running level
//   donkey_hit  in   1  1-cycle pulse: unshielded barrel hit
//   health_en   in   3  remaining-health bitmap
//   donkey_win  in   1  level: Donkey reached lady
//   kong_win    in   1  level: Donkey out of health
//   tx_ready    in   1  UART TX accepts tx_data this cycle
//   tx_data     out  8  byte to UART TX
//   tx_valid    out  1  tx_data valid
//   busy        out  1  frame in progress
module game_status_tx #(
  parameter int unsigned HEARTBEAT_CYCLES = 6_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_game,
  input  logic       game_en,
  input  logic       donkey_hit,
  input  logic [2:0] health_en,
  input  logic       donkey_win,
  input  logic       kong_win,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(HEARTBEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HEARTBEAT_CYCLES - 1);

  localparam logic [3:0] T_READY  = 4'd1;
  localparam logic [3:0] T_HIT    = 4'd2;
  localparam logic [3:0] T_RESULT = 4'd3;
  localparam logic [3:0] T_HBEAT  = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CHK} state_t;

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic             win_q, win_d;
  logic             ready_p_q, ready_p_d;
  logic             hit_p_q, hit_p_d;
  logic             result_p_q, result_p_d;
  logic             hb_p_q, hb_p_d;
  logic [CNT_W-1:0] hb_cnt_q, hb_cnt_d;
  logic [3:0]       type_q, type_d;
  logic [7:0]       pay_q, pay_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;

  logic take_ready, take_hit, take_result, take_hb;

  // FSM next state and byte sequencing. In IDLE the highest-priority
  // pending flag is taken and its payload is snapshotted from the live
  // inputs. Later input changes cannot corrupt a frame that is in flight.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    pay_d       = pay_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    take_ready  = 1'b0;
    take_hit    = 1'b0;
    take_result = 1'b0;
    take_hb     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (result_p_q) begin
          take_result = 1'b1;
          type_d      = T_RESULT;
          pay_d       = {6'b0, kong_win, donkey_win};
        end else if (hit_p_q) begin
          take_hit = 1'b1;
          type_d   = T_HIT;
          pay_d    = {5'b0, health_en};
        end else if (ready_p_q) begin
          take_ready = 1'b1;
          type_d     = T_READY;
          pay_d      = {7'b0, start_game};
        end else if (hb_p_q) begin
          take_hb = 1'b1;
          type_d  = T_HBEAT;
          pay_d   = {game_en, 4'b0, health_en};
        end
        if (result_p_q || hit_p_q || ready_p_q || hb_p_q) begin
          tx_data_d  = {4'hA, type_d};
          tx_valid_d = 1'b1;
          state_d    = S_HDR;
        end
      end
      // tx_valid is high in every non-idle state, so tx_ready alone
      // completes the handshake.
      S_HDR: begin
        if (tx_ready) begin
          tx_data_d = pay_q;
          state_d   = S_PAY;
        end
      end
      S_PAY: begin
        if (tx_ready) begin
          tx_data_d = {4'hA, type_q} ^ pay_q;
          state_d   = S_CHK;
        end
      end
      S_CHK: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Event detection and the pending flags. The OR with a new event comes
  // after the clear. An event in the same cycle as its flag is consumed
  // therefore queues a fresh frame.
  always_comb begin
    start_d    = start_game;
    win_d      = donkey_win | kong_win;
    ready_p_d  = (ready_p_q & ~take_ready) | (start_game ^ start_q);
    hit_p_d    = (hit_p_q & ~take_hit) | donkey_hit;
    result_p_d = (result_p_q & ~take_result) | (win_d & ~win_q);
    hb_p_d     = (hb_p_q & ~take_hb) | (game_en && (hb_cnt_q == CNT_LAST));
    if (!game_en || (hb_cnt_q == CNT_LAST)) begin
      hb_cnt_d = '0;
    end else begin
      hb_cnt_d = hb_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      win_q      <= 1'b0;
      ready_p_q  <= 1'b0;
      hit_p_q    <= 1'b0;
      result_p_q <= 1'b0;
      hb_p_q     <= 1'b0;
      hb_cnt_q   <= '0;
      type_q     <= 4'd0;
      pay_q      <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      win_q      <= win_d;
      ready_p_q  <= ready_p_d;
      hit_p_q    <= hit_p_d;
      result_p_q <= result_p_d;
      hb_p_q     <= hb_p_d;
      hb_cnt_q   <= hb_cnt_d;
      type_q     <= type_d;
      pay_q      <= pay_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_IDLE);

endmodule
